// File: rtl/toilet_dose_sequencer.sv
// Inlet dosing sequencer: doses each active reagent channel in ascending order,
// each followed by a closed-valve settle gap, then runs the mixer and a residency hold.
module toilet_dose_sequencer #(
    parameter int N_CH       = 3,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 4,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [N_CH-1:0]         ch_en,
    input  logic [N_CH*CNT_W-1:0]   dwell_cfg,
    input  logic [CNT_W-1:0]        mix_cfg,
    input  logic [CNT_W-1:0]        hold_cfg,
    output logic [N_CH-1:0]         valve_open,
    output logic                    mix_pump,
    output logic [CH_W-1:0]         cur_ch,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    typedef enum logic [2:0] {
        S_IDLE, S_DOSE, S_SETTLE, S_MIX, S_HOLD, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_TOP = CNT_W'(SETTLE_CYC - 1);

    state_t                      state, state_d;
    logic [CNT_W-1:0]            cnt, cnt_d;
    logic [CH_W-1:0]             ch_d;
    logic                        err_q, err_d;
    logic                        accept;

    logic [N_CH-1:0][CNT_W-1:0]  dwell_in, dwell_q;
    logic [N_CH-1:0]             act_in, act_q;
    logic [CNT_W-1:0]            mix_q, hold_q;

    logic                        first_found, nxt_found;
    logic [CH_W-1:0]             first_ch, nxt_ch;

    assign dwell_in = dwell_cfg;

    // A channel with a zero dwell is treated exactly like a disabled one.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            act_in[i] = ch_en[i] && (dwell_in[i] != '0);
        end
    end

    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (act_in[i]) begin
                first_found = 1'b1;
                first_ch    = CH_W'(i);
            end
        end
    end

    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (act_q[i] && (i > int'(cur_ch))) begin
                nxt_found = 1'b1;
                nxt_ch    = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
            act_q   <= '0;
            mix_q   <= '0;
            hold_q  <= '0;
        end else if (accept) begin
            dwell_q <= dwell_in;
            act_q   <= act_in;
            mix_q   <= mix_cfg;
            hold_q  <= hold_cfg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            cur_ch <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            cur_ch <= ch_d;
            err_q  <= err_d;
        end
    end

    // Counters hold (cycles-1) so a full-scale count never needs an extra bit.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ch_d    = cur_ch;
        err_d   = 1'b0;
        accept  = 1'b0;
        if (abort) begin
            if (state != S_IDLE) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                ch_d    = '0;
                err_d   = 1'b1;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        accept = 1'b1;
                        if (first_found) begin
                            state_d = S_DOSE;
                            ch_d    = first_ch;
                            cnt_d   = dwell_in[first_ch] - ONE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_DOSE: begin
                    if (cnt == '0) begin
                        state_d = S_SETTLE;
                        cnt_d   = SETTLE_TOP;
                    end else begin
                        cnt_d = cnt - ONE;
                    end
                end
                S_SETTLE: begin
                    if (cnt != '0) begin
                        cnt_d = cnt - ONE;
                    end else if (nxt_found) begin
                        state_d = S_DOSE;
                        ch_d    = nxt_ch;
                        cnt_d   = dwell_q[nxt_ch] - ONE;
                    end else if (mix_q != '0) begin
                        state_d = S_MIX;
                        cnt_d   = mix_q - ONE;
                    end else if (hold_q != '0) begin
                        state_d = S_HOLD;
                        cnt_d   = hold_q - ONE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_MIX: begin
                    if (cnt != '0) begin
                        cnt_d = cnt - ONE;
                    end else if (hold_q != '0) begin
                        state_d = S_HOLD;
                        cnt_d   = hold_q - ONE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_HOLD: begin
                    if (cnt != '0) begin
                        cnt_d = cnt - ONE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    ch_d    = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    ch_d    = '0;
                end
            endcase
        end
    end

    // Drives decode straight from state so the async reset closes valves at once.
    assign valve_open = (state == S_DOSE) ? (N_CH'(1) << cur_ch) : '0;
    assign mix_pump   = (state == S_MIX);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE) && !abort;
    assign err        = err_q;

endmodule

// File: tb/tb_toilet_dose_sequencer.sv
// Randomised bench for toilet_dose_sequencer against a per-cycle timeline model.
module tb_toilet_dose_sequencer;
    localparam int N_CH       = 3;
    localparam int CNT_W      = 16;
    localparam int SETTLE_CYC = 4;
    localparam int CH_W       = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic [N_CH-1:0]       ch_en = '0;
    logic [N_CH*CNT_W-1:0] dwell_cfg = '0;
    logic [CNT_W-1:0]      mix_cfg = '0;
    logic [CNT_W-1:0]      hold_cfg = '0;
    logic [N_CH-1:0]       valve_open;
    logic                  mix_pump;
    logic [CH_W-1:0]       cur_ch;
    logic                  busy;
    logic                  done;
    logic                  err;

    toilet_dose_sequencer #(.N_CH(N_CH), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ch_en(ch_en),
        .dwell_cfg(dwell_cfg), .mix_cfg(mix_cfg), .hold_cfg(hold_cfg),
        .valve_open(valve_open), .mix_pump(mix_pump), .cur_ch(cur_ch),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    typedef struct {
        int valve;   // -1 = all closed, else open channel index
        bit pump;
        bit busy;
        bit done;
        bit err;
    } exp_t;

    exp_t tl[$];

    // One entry per cycle after start is accepted, straight from the dosing rules.
    function automatic void build(input logic [N_CH-1:0] en, input logic [N_CH*CNT_W-1:0] dw,
                                  input int mix, input int hold);
        exp_t e;
        int   d;
        bit   any;
        tl.delete();
        any = 0;
        for (int i = 0; i < N_CH; i++) begin
            d = int'(dw[i*CNT_W +: CNT_W]);
            if (en[i] && d != 0) begin
                any = 1;
                e = '{valve: i, pump: 0, busy: 1, done: 0, err: 0};
                repeat (d) tl.push_back(e);
                e.valve = -1;
                repeat (SETTLE_CYC) tl.push_back(e);
            end
        end
        if (!any) begin
            e = '{valve: -1, pump: 0, busy: 0, done: 0, err: 1};
            tl.push_back(e);
            return;
        end
        e = '{valve: -1, pump: 1, busy: 1, done: 0, err: 0};
        repeat (mix) tl.push_back(e);
        e.pump = 0;
        repeat (hold) tl.push_back(e);
        e.done = 1;
        tl.push_back(e);
    endfunction

    task automatic cmp(input string tag, input int valve, input bit pump, input bit bsy,
                       input bit dn, input bit er);
        chk({tag, ".valve"}, valve_open, (valve < 0) ? 0 : (1 << valve));
        chk({tag, ".pump"}, mix_pump, pump);
        chk({tag, ".busy"}, busy, bsy);
        chk({tag, ".done"}, done, dn);
        chk({tag, ".err"}, err, er);
        chk({tag, ".onehot"}, $onehot0(valve_open), 1);
        chk({tag, ".excl"}, (|valve_open) && mix_pump, 0);
        if (valve >= 0) chk({tag, ".cur_ch"}, cur_ch, valve);
    endtask

    task automatic run_seq(input string tag, input logic [N_CH-1:0] en,
                           input logic [N_CH*CNT_W-1:0] dw, input int mix, input int hold,
                           input int abort_at, input bit noise);
        int L;
        build(en, dw, mix, hold);
        L = tl.size();
        @(posedge clk); #1;
        start = 1; abort = 0;
        ch_en = en; dwell_cfg = dw; mix_cfg = CNT_W'(mix); hold_cfg = CNT_W'(hold);
        #1;
        cmp({tag, "@0"}, -1, 0, 0, 0, 0);
        for (int k = 1; k <= L + 1; k++) begin
            @(posedge clk); #1;
            start = (noise && k < L) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                ch_en     = N_CH'($urandom);
                dwell_cfg = {N_CH{CNT_W'($urandom_range(0, 9))}};
                mix_cfg   = CNT_W'($urandom_range(0, 9));
                hold_cfg  = CNT_W'($urandom_range(0, 9));
            end
            abort = (k == abort_at);
            #1;
            if (k <= L) cmp(tag, tl[k-1].valve, tl[k-1].pump, tl[k-1].busy,
                            tl[k-1].done && !abort, tl[k-1].err);
            else cmp({tag, ".tail"}, -1, 0, 0, 0, 0);
            if (abort && k <= L && tl[k-1].busy) begin
                @(posedge clk); #1;
                abort = 0; start = 0;
                #1;
                cmp({tag, ".abort"}, -1, 0, 0, 0, 1);
                break;
            end
        end
        start = 0; abort = 0;
    endtask

    function automatic logic [N_CH*CNT_W-1:0] pack3(input int d0, input int d1, input int d2);
        return {CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
    endfunction

    initial begin
        logic [N_CH-1:0]       en;
        logic [N_CH*CNT_W-1:0] dw;
        int                    waited;

        #12;
        cmp("reset", -1, 0, 0, 0, 0);
        chk("reset.cur_ch", cur_ch, 0);
        @(posedge clk); #1 rst_n = 1;

        run_seq("plan1", 3'b111, pack3(5, 3, 2), 6, 4, 0, 0);
        run_seq("skip1", 3'b101, pack3(2, 7, 3), 2, 1, 0, 0);
        run_seq("empty", 3'b011, pack3(0, 0, 5), 3, 3, 0, 0);
        run_seq("abort12", 3'b111, pack3(5, 3, 2), 6, 4, 12, 0);
        repeat (1) @(posedge clk);
        run_seq("restart", 3'b111, pack3(5, 3, 2), 6, 4, 0, 0);
        run_seq("minimal", 3'b001, pack3(1, 0, 0), 0, 0, 0, 0);
        run_seq("abort_done", 3'b010, pack3(0, 2, 0), 1, 1, 8, 0);
        run_seq("noise", 3'b111, pack3(3, 4, 2), 5, 3, 0, 1);

        // start and abort together in IDLE: nothing happens
        @(posedge clk); #1;
        start = 1; abort = 1; ch_en = 3'b111; dwell_cfg = pack3(2, 2, 2);
        @(posedge clk); #1;
        start = 0; abort = 0;
        #1;
        cmp("start_abort", -1, 0, 0, 0, 0);

        for (int r = 0; r < 30; r++) begin
            en = N_CH'($urandom);
            for (int i = 0; i < N_CH; i++)
                dw[i*CNT_W +: CNT_W] = ($urandom_range(0, 9) < 3) ? '0 : CNT_W'($urandom_range(1, 6));
            run_seq($sformatf("rand%0d", r), en, dw, $urandom_range(0, 5), $urandom_range(0, 4),
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0, 1);
        end

        // reset dropped during MIX clears the pump without waiting for a clock
        @(posedge clk); #1;
        start = 1; ch_en = 3'b001; dwell_cfg = pack3(2, 0, 0); mix_cfg = 20; hold_cfg = 3;
        @(posedge clk); #1 start = 0;
        waited = 0;
        while (!mix_pump && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("mix_reached", mix_pump, 1);
        #2 rst_n = 0;
        #1;
        cmp("async_rst", -1, 0, 0, 0, 0);
        @(posedge clk); #1 rst_n = 1;

        run_seq("fullscale", 3'b001, pack3(65535, 0, 0), 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
